// File: rtl/boa_div_iter.sv
// Iterative radix-2 restoring divider, signed or unsigned, with valid/ready handshake.
// One quotient bit per cycle in CALC, sign fix-up in FIX, result held in DONE.
// Optional build macro BOA_DIV_EARLY_EXIT_EN: requests with |lhs| < |rhs| skip CALC
// and complete with quot = 0, rem = lhs on the cycle after accept.
module boa_div_iter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             u,
   input  logic [WIDTH-1:0] lhs,
   input  logic [WIDTH-1:0] rhs,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem
);

   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] quot_q;   // dividend shifts out MSB first, quotient bits shift in
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] div_q;
   logic [CW-1:0]    cnt_q;
   logic             sq_q, sr_q;

   logic             accept;
   logic             lhs_neg, rhs_neg;
   logic [WIDTH-1:0] lhs_mag, rhs_mag;
   logic             div_zero, early, fast;
   logic [WIDTH:0]   shifted, diff;
   logic             take;

   assign accept   = in_valid && in_ready && !flush;
   assign lhs_neg  = !u && lhs[WIDTH-1];
   assign rhs_neg  = !u && rhs[WIDTH-1];
   // Most negative value maps to itself, which is the correct unsigned magnitude.
   assign lhs_mag  = lhs_neg ? -lhs : lhs;
   assign rhs_mag  = rhs_neg ? -rhs : rhs;
   assign div_zero = (rhs == '0);
`ifdef BOA_DIV_EARLY_EXIT_EN
   assign early    = !div_zero && (lhs_mag < rhs_mag);
`else
   assign early    = 1'b0;
`endif
   assign fast     = div_zero || early;

   // Restoring step on the WIDTH+1 bit partial remainder; MSB of diff set means "negative".
   assign shifted  = {rem_q, quot_q[WIDTH-1]};
   assign diff     = shifted - {1'b0, div_q};
   assign take     = !diff[WIDTH];

   assign in_ready  = (state_q == StIdle) && !rst;
   assign out_valid = (state_q == StDone);
   assign quot      = quot_q;
   assign rem       = rem_q;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; flush overrides every other transition.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (accept) state_d = fast ? StDone : StCalc;
         StCalc:  if (cnt_q == '0) state_d = StFix;
         StFix:   state_d = StDone;
         StDone:  if (out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (flush) begin
         state_d = StIdle;
      end
   end

   // Datapath: operand capture, iteration and sign fix-up.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         quot_q <= '0;
         rem_q  <= '0;
         div_q  <= '0;
         cnt_q  <= '0;
         sq_q   <= 1'b0;
         sr_q   <= 1'b0;
      end else if (!flush) begin
         case (state_q)
            StIdle: begin
               if (accept) begin
                  div_q <= rhs_mag;
                  cnt_q <= CW'(WIDTH - 1);
                  sq_q  <= lhs_neg ^ rhs_neg;
                  sr_q  <= lhs_neg;
                  if (fast) begin
                     // Divide by zero gives all ones; early exit gives zero.
                     quot_q <= div_zero ? '1 : '0;
                     rem_q  <= lhs;
                  end else begin
                     quot_q <= lhs_mag;
                     rem_q  <= '0;
                  end
               end
            end
            StCalc: begin
               quot_q <= {quot_q[WIDTH-2:0], take};
               rem_q  <= take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            StFix: begin
               if (sq_q) quot_q <= -quot_q;
               if (sr_q) rem_q  <= -rem_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_boa_div_iter.sv
// Self-checking bench for boa_div_iter: directed vectors with literal expectations,
// an arithmetic reference model, and a per-cycle compare process on out_valid.
module tb_boa_div_iter;

`ifdef BOA_DIV_EARLY_EXIT_EN
   localparam int EE_LAT = 1;
`else
   localparam int EE_LAT = 34;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        u = 1'b0;
   logic [31:0] lhs = '0;
   logic [31:0] rhs = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] quot;
   logic [31:0] rem;

   logic        u8 = 1'b0;
   logic [7:0]  lhs8 = '0;
   logic [7:0]  rhs8 = '0;
   logic        in_valid8 = 1'b0;
   logic        in_ready8;
   logic        out_valid8;
   logic        out_ready8 = 1'b1;
   logic [7:0]  quot8;
   logic [7:0]  rem8;

   int          n_cmp = 0;
   int          n_fail = 0;
   logic [31:0] exp_q = '0;
   logic [31:0] exp_r = '0;
   bit          forbid = 1'b0;

   always #5 clk = ~clk;

   boa_div_iter #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .u(u), .lhs(lhs), .rhs(rhs), .in_valid(in_valid),
      .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .quot(quot), .rem(rem)
   );

   boa_div_iter #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .u(u8), .lhs(lhs8), .rhs(rhs8), .in_valid(in_valid8),
      .in_ready(in_ready8), .flush(1'b0), .out_valid(out_valid8), .out_ready(out_ready8),
      .quot(quot8), .rem(rem8)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: 64-bit arithmetic, no overflow at the most negative / -1 corner.
   function automatic void model(input bit uu, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r);
      longint sa, sb;
      if (b == 32'd0) begin
         q = '1;
         r = a;
      end else if (uu) begin
         q = a / b;
         r = a % b;
      end else begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q = 32'(sa / sb);
         r = 32'(sa % sb);
      end
   endfunction

   // Every cycle with a result on the port: it must match the model and nothing is expected
   // while an aborted operation is being watched.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (forbid) begin
            check("unexpected_out_valid", 64'(out_valid), 64'd0);
         end else begin
            check("quot", 64'(quot), 64'(exp_q));
            check("rem", 64'(rem), 64'(exp_r));
         end
      end
   end

   // Caller is at a negedge; ends at a negedge with the block back in IDLE.
   task automatic do_op(input bit uu, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] lit_q, input logic [31:0] lit_r,
                        input int lit_lat, input int hold);
      logic [31:0] mq, mr;
      int lat;
      model(uu, a, b, mq, mr);
      check("model_q", 64'(mq), 64'(lit_q));
      check("model_r", 64'(mr), 64'(lit_r));
      exp_q = mq;
      exp_r = mr;
      u = uu;
      lhs = a;
      rhs = b;
      in_valid = 1'b1;
      #1 check("in_ready_idle", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      // Operands must be ignored after accept.
      in_valid = 1'b0;
      lhs = ~a;
      rhs = b + 32'd1;
      u = ~uu;
      lat = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         lat++;
         if (out_valid) break;
      end
      check("latency", 64'(lat), 64'(lit_lat));
      check("in_ready_busy", 64'(in_ready), 64'd0);
      repeat (hold) @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      check("released_valid", 64'(out_valid), 64'd0);
      check("released_ready", 64'(in_ready), 64'd1);
   endtask

   initial begin
      int lat;
      repeat (2) @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_quot", 64'(quot), 64'd0);
      check("rst_rem", 64'(rem), 64'd0);
      rst = 1'b0;

      do_op(1'b0, 32'hFFFFFFF9, 32'd2,          32'hFFFFFFFD, 32'hFFFFFFFF, 34, 0);
      do_op(1'b1, 32'hFFFFFFFF, 32'h10,         32'h0FFFFFFF, 32'hF,        34, 5);
      do_op(1'b0, 32'hFFFFFFFB, 32'd0,          32'hFFFFFFFF, 32'hFFFFFFFB, 1,  2);
      do_op(1'b0, 32'h80000000, 32'hFFFFFFFF,   32'h80000000, 32'h0,        34, 0);
      do_op(1'b1, 32'd3,        32'd10,         32'h0,        32'h3,        EE_LAT, 0);
      do_op(1'b0, 32'd100,      32'hFFFFFFF9,   32'hFFFFFFF2, 32'h2,        34, 1);
      do_op(1'b0, 32'hFFFFFF9C, 32'd7,          32'hFFFFFFF2, 32'hFFFFFFFE, 34, 0);
      do_op(1'b1, 32'h80000000, 32'd3,          32'h2AAAAAAA, 32'h2,        34, 0);
      do_op(1'b1, 32'd5,        32'd0,          32'hFFFFFFFF, 32'h5,        1,  0);
      do_op(1'b1, 32'd0,        32'd5,          32'h0,        32'h0,        EE_LAT, 0);

      // Flush in CALC cycle 10 abandons the operation.
      forbid = 1'b1;
      u = 1'b1; lhs = 32'd1000; rhs = 32'd3; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      check("flush_out_valid", 64'(out_valid), 64'd0);
      check("flush_in_ready", 64'(in_ready), 64'd1);
      repeat (40) @(negedge clk);

      // Reset mid-CALC on a second request.
      u = 1'b0; lhs = 32'd5000; rhs = 32'd9; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_in_ready", 64'(in_ready), 64'd0);
      check("mid_rst_quot", 64'(quot), 64'd0);
      check("mid_rst_rem", 64'(rem), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      forbid = 1'b0;
      do_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 34, 0);

      // Flush beats a simultaneous accept (a divide by zero would otherwise finish next cycle).
      forbid = 1'b1;
      u = 1'b0; lhs = 32'd5; rhs = 32'd0; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("flush_vs_accept", 64'(out_valid), 64'd0);
      forbid = 1'b0;

      // Flush beats out_ready in DONE.
      exp_q = 32'hFFFFFFFF; exp_r = 32'd5;
      u = 1'b1; lhs = 32'd5; rhs = 32'd0; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      check("done_before_flush", 64'(out_valid), 64'd1);
      out_ready = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("flush_in_done", 64'(out_valid), 64'd0);
      check("flush_in_done_ready", 64'(in_ready), 64'd1);

      // WIDTH=8: 100/7 signed.
      u8 = 1'b0; lhs8 = 8'd100; rhs8 = 8'd7; in_valid8 = 1'b1;
      #1 check("w8_in_ready", 64'(in_ready8), 64'd1);
      @(posedge clk);
      #1 in_valid8 = 1'b0; lhs8 = 8'd1;
      lat = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         lat++;
         if (out_valid8) break;
      end
      check("w8_latency", 64'(lat), 64'd10);
      check("w8_quot", 64'(quot8), 64'd14);
      check("w8_rem", 64'(rem8), 64'd2);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/boa_div_iter.md
BOA_DIV_ITER -- requirements
Module: boa_div_iter

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; legal range 8..64.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 u  input  1  1 = unsigned divide, 0 = signed (two's complement); sampled on accept.
REQ-005 lhs  input  WIDTH  dividend; sampled on accept.
REQ-006 rhs  input  WIDTH  divisor; sampled on accept.
REQ-007 in_valid  input  1  request present.
REQ-008 in_ready  output  1  block can accept a request.
REQ-009 flush  input  1  synchronous abort of any in-flight operation.
REQ-010 out_valid  output  1  quot/rem hold a valid result.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 quot  output  WIDTH  quotient.
REQ-013 rem  output  WIDTH  remainder.

Function
REQ-014 States SHALL be IDLE, CALC, FIX and DONE; in_ready SHALL be 1 only in IDLE and only while rst is low.
REQ-015 Accept SHALL occur on a rising edge with in_valid && in_ready && !flush; IDLE -> CALC, and the iteration counter loads WIDTH-1.
REQ-016 On accept, signed mode SHALL latch |lhs| and |rhs| plus sign flags sq = lhs[MSB]^rhs[MSB] and sr = lhs[MSB]; unsigned mode SHALL latch raw operands with both flags 0.
REQ-017 CALC SHALL perform one radix-2 restoring step per cycle, MSB first, for exactly WIDTH cycles; the partial remainder is WIDTH+1 bits wide.
REQ-018 After counter 0, CALC SHALL move to FIX; FIX SHALL negate quot if sq and rem if sr, then move to DONE.
REQ-019 out_valid SHALL be 1 exactly in DONE; normal latency SHALL be WIDTH+2 edges from the accept edge to the first cycle with out_valid=1.
REQ-020 quot and rem SHALL stay stable while out_valid=1; DONE -> IDLE on an edge with out_ready=1.
REQ-021 Divide by zero SHALL bypass CALC: accept edge -> DONE with quot = all ones and rem = lhs (unmodified), in both signed and unsigned modes.
REQ-022 Signed overflow (lhs = most negative, rhs = -1) SHALL yield quot = most negative and rem = 0 through the normal path.
REQ-023 Remainder sign SHALL follow the dividend; quotient SHALL truncate toward zero.
REQ-024 flush=1 on any edge SHALL force IDLE, clear out_valid and discard the operation; flush SHALL take priority over accept and over out_ready.
REQ-025 in_valid/lhs/rhs/u SHALL be ignored outside IDLE; operand changes after accept SHALL not affect the result.

Reset
REQ-026 While rst=1: state IDLE, out_valid 0, in_ready 0, quot 0, rem 0, counter 0, sign flags 0.
REQ-027 rst asserted mid-operation SHALL abandon it with no out_valid pulse; the first accept SHALL be possible on the first edge after rst deasserts.

Configuration
REQ-028 Macro BOA_DIV_EARLY_EXIT_EN: when defined, an accepted request with |lhs| < |rhs| (magnitudes per mode, rhs != 0) SHALL go accept edge -> DONE with quot = 0 and rem = lhs (unmodified), so out_valid=1 in the cycle after accept.
REQ-029 Without BOA_DIV_EARLY_EXIT_EN, such requests SHALL take the normal WIDTH+2 latency with identical results; only divide by zero takes the fast path.

Verification
REQ-030 WIDTH=32, u=0, lhs=-7, rhs=2 -> quot=-3 (0xFFFFFFFD), rem=-1 (0xFFFFFFFF), out_valid first high 34 cycles after accept.
REQ-031 WIDTH=32, u=1, lhs=0xFFFFFFFF, rhs=0x10 -> quot=0x0FFFFFFF, rem=0xF; out_ready held 0 for 5 cycles -> outputs stable, then IDLE.
REQ-032 rhs=0, lhs=-5, u=0 -> quot=0xFFFFFFFF, rem=0xFFFFFFFB, out_valid one cycle after accept.
REQ-033 u=0, lhs=0x80000000, rhs=0xFFFFFFFF -> quot=0x80000000, rem=0.
REQ-034 flush pulse in CALC cycle 10, then rst pulse mid-CALC on a second request -> no out_valid either time; a third request (100/7) completes with quot=14, rem=2.
REQ-035 lhs=3, rhs=10, u=1 -> quot=0, rem=3; latency 1 cycle with BOA_DIV_EARLY_EXIT_EN defined, 34 cycles without; WIDTH=8 repeat of 100/7 -> latency 10.
